seq_decode_unit: RTL

- Parametrised, registered successor to the fixed 3-to-8 opcode decoder in the control path.
- Latches the instruction opcode field and the indirect bit, and produces a registered one-hot opcode vector D with a valid flag.
- Owns the control sequence counter SC and its one-hot timing vector T.
- Sits between the instruction register and control-signal logic; the control block consumes D, ind, T and issues sc_inc and sc_clr.

---
 rtl/seq_decode_unit_pkg.sv | 37 +++
 rtl/seq_decode_unit_onehot_decoder.sv | 27 ++
 rtl/seq_decode_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/seq_decode_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_decode_unit_pkg
// Purpose : Shared widths, width helpers and opcode names for the sequence
//           decode unit and its one-hot decoder.
// Ports   : none (package)
// Revision: 1.0 - initial parametrised release
// ============================================================================
package seq_decode_unit_pkg;

  localparam int DEF_OP_WIDTH = 3;
  localparam int DEF_SC_WIDTH = 4;

  // Width of the one-hot opcode vector D for a given opcode field width.
  function automatic int d_width(input int op_width);
    return 1 << op_width;
  endfunction

  // Width of the one-hot timing vector T for a given counter width.
  function automatic int t_width(input int sc_width);
    return 1 << sc_width;
  endfunction

  // Named opcode indices for the default 3-bit opcode field.
  typedef enum logic [DEF_OP_WIDTH-1:0] {
    OP_AND    = 3'd0,
    OP_ADD    = 3'd1,
    OP_LDA    = 3'd2,
    OP_STA    = 3'd3,
    OP_BUN    = 3'd4,
    OP_BSA    = 3'd5,
    OP_ISZ    = 3'd6,
    OP_IO_REG = 3'd7
  } opcode_e;

endpackage
`default_nettype wire

// File: rtl/seq_decode_unit_onehot_decoder.sv
`default_nettype none
// ============================================================================
// Module  : onehot_decoder
// Purpose : Pure combinational N-to-2**N one-hot decoder.
// Ports   : sel_in     [IN_WIDTH-1:0]      binary select
//           onehot_out [2**IN_WIDTH-1:0]   onehot_out[sel_in] = 1, others 0
// Revision: 1.0 - initial parametrised release
// ============================================================================
module onehot_decoder
  import seq_decode_unit_pkg::*;
#(
  parameter int IN_WIDTH = DEF_OP_WIDTH
) (
  input  logic [IN_WIDTH-1:0]           sel_in,
  output logic [d_width(IN_WIDTH)-1:0]  onehot_out
);

  localparam int OUT_W = d_width(IN_WIDTH);

  // Each output bit is an independent equality compare, so exactly one bit
  // is high for any known select value.
  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
    assign onehot_out[gi] = (sel_in == IN_WIDTH'(gi));
  end

endmodule
`default_nettype wire

// File: rtl/seq_decode_unit.sv
`default_nettype none
// ============================================================================
// Module  : seq_decode_unit
// Purpose : Registered opcode decoder plus control sequence counter with its
//           one-hot timing vector.
// Ports   : clk, reset_n (async active-low)
//           ir_load, op_in[OP_WIDTH], ind_in  - instruction register fields
//           sc_inc, sc_clr                    - sequence counter control
//           d_out[2**OP_WIDTH], d_valid, ind  - registered decode
//           sc[SC_WIDTH], t_out[2**SC_WIDTH]  - counter and timing vector
//           sc_wrap                           - one-cycle wrap/overflow pulse
// Revision: 1.0 - initial parametrised release
// ============================================================================
module seq_decode_unit
  import seq_decode_unit_pkg::*;
#(
  parameter int OP_WIDTH = DEF_OP_WIDTH,
  parameter int SC_WIDTH = DEF_SC_WIDTH,
  parameter int SC_WRAP  = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ir_load,
  input  logic [OP_WIDTH-1:0]           op_in,
  input  logic                          ind_in,
  input  logic                          sc_inc,
  input  logic                          sc_clr,
  output logic [d_width(OP_WIDTH)-1:0]  d_out,
  output logic                          d_valid,
  output logic                          ind,
  output logic [SC_WIDTH-1:0]           sc,
  output logic [t_width(SC_WIDTH)-1:0]  t_out,
  output logic                          sc_wrap
);

  localparam int                D_W    = d_width(OP_WIDTH);
  localparam logic [SC_WIDTH-1:0] SC_MAX = '1;

  logic [OP_WIDTH-1:0] op_sel;
  logic [D_W-1:0]      op_onehot;

  logic [D_W-1:0]      d_d,       d_q;
  logic                d_valid_d, d_valid_q;
  logic                ind_d,     ind_q;
  logic [SC_WIDTH-1:0] sc_d,      sc_q;
  logic                sc_wrap_d, sc_wrap_q;

  // op_in is only looked at when a load is requested, so an undriven opcode
  // bus between instructions never reaches the decoder.
  assign op_sel = ir_load ? op_in : '0;

  onehot_decoder #(.IN_WIDTH(OP_WIDTH)) u_op_dec (
    .sel_in     (op_sel),
    .onehot_out (op_onehot)
  );

  always_comb begin
    d_d       = d_q;
    d_valid_d = d_valid_q;
    ind_d     = ind_q;
    sc_d      = sc_q;
    sc_wrap_d = 1'b0;

    // A load on the same edge as a clear starts the next instruction, so it
    // wins over retirement of the current one.
    if (ir_load) begin
      d_d       = op_onehot;
      ind_d     = ind_in;
      d_valid_d = 1'b1;
    end else if (sc_clr) begin
      d_valid_d = 1'b0;
    end

    if (sc_clr) begin
      sc_d = '0;
    end else if (sc_inc) begin
      if (sc_q == SC_MAX) begin
        sc_wrap_d = 1'b1;
        if (SC_WRAP != 0) begin
          sc_d = '0;
        end
      end else begin
        sc_d = sc_q + SC_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q       <= '0;
      d_valid_q <= 1'b0;
      ind_q     <= 1'b0;
      sc_q      <= '0;
      sc_wrap_q <= 1'b0;
    end else begin
      d_q       <= d_d;
      d_valid_q <= d_valid_d;
      ind_q     <= ind_d;
      sc_q      <= sc_d;
      sc_wrap_q <= sc_wrap_d;
    end
  end

  // T is decoded straight from the counter flops, so it only changes on clk
  // and shows T0 while reset holds sc at zero.
  onehot_decoder #(.IN_WIDTH(SC_WIDTH)) u_t_dec (
    .sel_in     (sc_q),
    .onehot_out (t_out)
  );

  assign d_out   = d_q;
  assign d_valid = d_valid_q;
  assign ind     = ind_q;
  assign sc      = sc_q;
  assign sc_wrap = sc_wrap_q;

endmodule
`default_nettype wire
